// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 keyboard receiver with clock glitch filter, frame checking,
// optional E0/F0 prefix decoding and a first-word-fall-through receive FIFO.
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH     = 16,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter bit DECODE         = 1'b1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          kb_clk_i,
  input  logic                          kb_dat_i,
  input  logic                          rd_i,
  input  logic                          clr_err_i,
  output logic                          valid_o,
  output logic [9:0]                    data_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          parity_err_o,
  output logic                          frame_err_o,
  output logic                          overflow_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_e;
  state_e state_q, state_d;
  logic [1:0] clk_sync_q, dat_sync_q;
  logic filt_q, filt_d;
  logic [3:0] fcnt_q, fcnt_d;
  logic [3:0] idx_q, idx_d;
  logic [9:0] sr_q, sr_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic pend_ext_q, pend_ext_d, pend_brk_q, pend_brk_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;
  logic [9:0] mem_q [FIFO_DEPTH];
  logic fall, push, pop, full, wr_en, set_perr, set_ferr;
  logic [9:0] push_data;
  // The filtered level flips only after FILTER_LEN cycles of disagreement.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (fcnt_q == 4'(FILTER_LEN)) filt_d = clk_sync_q[1];
      else fcnt_d = fcnt_q + 4'd1;
    end
    fall = filt_q & ~filt_d;
  end
  // sr_q collects data[7:0], parity and stop, shifted in LSB first.
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    sr_d = sr_q;
    tcnt_d = '0;
    pend_ext_d = pend_ext_q;
    pend_brk_d = pend_brk_q;
    push = 1'b0;
    push_data = {pend_ext_q, pend_brk_q, sr_q[7:0]};
    set_perr = 1'b0;
    set_ferr = 1'b0;
    case (state_q)
      IDLE: if (fall && !dat_sync_q[1]) begin
        state_d = RECV;
        idx_d = 4'd1;
      end
      RECV: if (fall) begin
        sr_d = {dat_sync_q[1], sr_q[9:1]};
        idx_d = idx_q + 4'd1;
        state_d = idx_q == 4'd10 ? CHECK : RECV;
      end else if (tcnt_q == TW'(TIMEOUT_CYCLES)) begin
        set_ferr = 1'b1;
        state_d = IDLE;
        pend_ext_d = 1'b0;
        pend_brk_d = 1'b0;
      end else tcnt_d = tcnt_q + TW'(1);
      CHECK: begin
        state_d = IDLE;
        if (!(^sr_q[8:0]) || !sr_q[9]) begin
          set_perr = !(^sr_q[8:0]);
          set_ferr = ^sr_q[8:0];
          pend_ext_d = 1'b0;
          pend_brk_d = 1'b0;
        end else if (DECODE && sr_q[7:0] == 8'hE0) pend_ext_d = 1'b1;
        else if (DECODE && sr_q[7:0] == 8'hF0) pend_brk_d = 1'b1;
        else begin
          push = 1'b1;
          pend_ext_d = 1'b0;
          pend_brk_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    full = cnt_q == CW'(FIFO_DEPTH);
    pop = rd_i && cnt_q != '0;
    wr_en = push && (!full || pop);
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    cnt_d = cnt_q + CW'(wr_en) - CW'(pop);
    perr_d = set_perr | (perr_q & ~clr_err_i);
    ferr_d = set_ferr | (ferr_q & ~clr_err_i);
    ovf_d = (push & full & ~pop) | (ovf_q & ~clr_err_i);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      filt_q <= 1'b1;
      fcnt_q <= '0;
      state_q <= IDLE;
      idx_q <= '0;
      sr_q <= '0;
      tcnt_q <= '0;
      pend_ext_q <= 1'b0;
      pend_brk_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], kb_clk_i};
      dat_sync_q <= {dat_sync_q[0], kb_dat_i};
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
      state_q <= state_d;
      idx_q <= idx_d;
      sr_q <= sr_d;
      tcnt_q <= tcnt_d;
      pend_ext_q <= pend_ext_d;
      pend_brk_q <= pend_brk_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q <= cnt_d;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
      ovf_q <= ovf_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data;
  end
  assign valid_o = cnt_q != '0;
  assign data_o = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = cnt_q;
  assign parity_err_o = perr_q;
  assign frame_err_o = ferr_q;
  assign overflow_o = ovf_q;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: directed vectors and corner-case sequences for ps2_rx_fifo
// with DECODE=1 (main) and DECODE=0 (raw) instances sharing the PS/2 lines.
module tb_ps2_rx_fifo;
  localparam int H = 16;
  logic clk = 1'b0, rst_n = 1'b0, kb_clk = 1'b1, kb_dat = 1'b1;
  logic rd = 1'b0, rd2 = 1'b0, clr = 1'b0;
  logic valid, valid2, perr, perr2, ferr, ferr2, ovf, ovf2;
  logic [9:0] data, data2;
  logic [4:0] count, count2;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    logic [7:0] code;
    bit bad_par;
    bit bad_stop;
    logic exp_valid;
    logic [9:0] exp_data;
    logic exp_perr;
    logic exp_ferr;
  } vec_t;
  vec_t vecs [13];
  always #5 clk = ~clk;
  ps2_rx_fifo #(.FIFO_DEPTH(16), .FILTER_LEN(4), .TIMEOUT_CYCLES(5000), .DECODE(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .kb_clk_i(kb_clk), .kb_dat_i(kb_dat), .rd_i(rd),
    .clr_err_i(clr), .valid_o(valid), .data_o(data), .count_o(count),
    .parity_err_o(perr), .frame_err_o(ferr), .overflow_o(ovf));
  ps2_rx_fifo #(.FIFO_DEPTH(16), .FILTER_LEN(4), .TIMEOUT_CYCLES(5000), .DECODE(1'b0)) dut_raw (
    .clk_i(clk), .rst_ni(rst_n), .kb_clk_i(kb_clk), .kb_dat_i(kb_dat), .rd_i(rd2),
    .clr_err_i(clr), .valid_o(valid2), .data_o(data2), .count_o(count2),
    .parity_err_o(perr2), .frame_err_o(ferr2), .overflow_o(ovf2));
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  // Bits change while kb_clk is high; rd_stop pulses rd_i in the CHECK cycle of the frame.
  task automatic send(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                      input int nbits, input bit glitch, input bit rd_stop);
    logic [10:0] fr;
    fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      kb_dat = fr[i];
      if (glitch) begin
        cyc(8);
        kb_clk = 1'b0;
        cyc(2);
        kb_clk = 1'b1;
        cyc(H - 10);
      end else cyc(H);
      kb_clk = 1'b0;
      if (rd_stop && i == 10) begin
        cyc(7);
        rd = 1'b1;
        cyc(1);
        rd = 1'b0;
        cyc(H - 8);
      end else cyc(H);
      kb_clk = 1'b1;
    end
    kb_dat = 1'b1;
    cyc(20);
  endtask
  task automatic send_ok(input logic [7:0] b);
    send(b, 1'b0, 1'b0, 11, 1'b0, 1'b0);
  endtask
  task automatic pop();
    rd = 1'b1;
    cyc(1);
    rd = 1'b0;
    cyc(1);
  endtask
  task automatic pop2();
    rd2 = 1'b1;
    cyc(1);
    rd2 = 1'b0;
    cyc(1);
  endtask
  task automatic clear();
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    cyc(1);
  endtask
  initial begin
    vecs[0]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 10'h01C, 1'b0, 1'b0};
    vecs[1]  = '{8'h1C, 1'b1, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0};
    vecs[2]  = '{8'h1C, 1'b0, 1'b1, 1'b0, 10'h000, 1'b0, 1'b1};
    vecs[3]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0};
    vecs[4]  = '{8'h33, 1'b1, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0};
    vecs[5]  = '{8'h33, 1'b0, 1'b0, 1'b1, 10'h033, 1'b0, 1'b0};
    vecs[6]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0};
    vecs[7]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 10'h11C, 1'b0, 1'b0};
    vecs[8]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0};
    vecs[9]  = '{8'h12, 1'b0, 1'b1, 1'b0, 10'h000, 1'b0, 1'b1};
    vecs[10] = '{8'hFF, 1'b0, 1'b0, 1'b1, 10'h0FF, 1'b0, 1'b0};
    vecs[11] = '{8'h00, 1'b0, 1'b0, 1'b1, 10'h000, 1'b0, 1'b0};
    vecs[12] = '{8'h5A, 1'b0, 1'b0, 1'b1, 10'h05A, 1'b0, 1'b0};
    cyc(3);
    check("rst_valid", valid, 0);
    check("rst_data", data, 0);
    rst_n = 1'b1;
    cyc(1000);
    check("idle_valid", valid, 0);
    check("idle_count", count, 0);
    check("idle_flags", {perr, ferr, ovf}, 0);
    send_ok(8'hE0);
    send_ok(8'hF0);
    send_ok(8'h75);
    check("pfx_count", count, 1);
    check("pfx_data", data, 10'h375);
    pop();
    check("pfx_empty", valid, 0);
    check("raw_count", count2, 3);
    check("raw_d0", data2, 10'h0E0);
    pop2();
    check("raw_d1", data2, 10'h0F0);
    pop2();
    check("raw_d2", data2, 10'h075);
    pop2();
    check("raw_empty", valid2, 0);
    for (int i = 0; i < 13; i++) begin
      clear();
      send(vecs[i].code, vecs[i].bad_par, vecs[i].bad_stop, 11, 1'b0, 1'b0);
      check($sformatf("vec%0d_valid", i), valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) check($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
      check($sformatf("vec%0d_perr", i), perr, vecs[i].exp_perr);
      check($sformatf("vec%0d_ferr", i), ferr, vecs[i].exp_ferr);
      if (vecs[i].exp_valid) pop();
    end
    clear();
    send(8'h1C, 1'b0, 1'b0, 5, 1'b0, 1'b0);
    cyc(4000);
    check("tmo_early", ferr, 0);
    cyc(1300);
    check("tmo_ferr", ferr, 1);
    check("tmo_nopush", valid, 0);
    send_ok(8'h29);
    check("tmo_next", data, 10'h029);
    check("tmo_count", count, 1);
    pop();
    clear();
    check("clr_flags", {perr, ferr, ovf}, 0);
    send(8'h1C, 1'b0, 1'b0, 11, 1'b1, 1'b0);
    check("glitch_count", count, 1);
    check("glitch_data", data, 10'h01C);
    check("glitch_ferr", {perr, ferr}, 0);
    pop();
    for (int i = 0; i < 17; i++) send_ok(8'h40 + 8'(i));
    check("ovf_count", count, 16);
    check("ovf_flag", ovf, 1);
    check("ovf_head", data, 10'h040);
    clear();
    send(8'h70, 1'b0, 1'b0, 11, 1'b0, 1'b1);
    check("full_rw_count", count, 16);
    check("full_rw_ovf", ovf, 0);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("rb%0d", k), data, k < 15 ? 32'h41 + 32'(k) : 32'h70);
      pop();
    end
    check("rb_empty", valid, 0);
    send(8'hAA, 1'b0, 1'b0, 5, 1'b0, 1'b0);
    rst_n = 1'b0;
    cyc(2);
    check("midrst_count", count, 0);
    check("midrst_valid", valid, 0);
    rst_n = 1'b1;
    cyc(5);
    send_ok(8'h6B);
    check("post_rst_count", count, 1);
    check("post_rst_data", data, 10'h06B);
    check("post_rst_flags", {perr, ferr, ovf}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
